// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the SPI register bank: FSM states and address-byte field layout.
package spi_reg_bank_pkg;

   localparam int SPI_RW_BIT  = 7;
   localparam int SPI_ADDR_W  = 7;
   localparam int BYTE_W_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ
   } state_t;

endpackage

// File: rtl/spi_reg_bank_if.sv
// Byte-level link between the SPI core (master side) and the register bank (slave side).
interface spi_reg_bank_if #(
   parameter int BYTE_W = 8
);

   logic [BYTE_W-1:0] spi_address_rx;
   logic              spi_address_rx_valid;
   logic [BYTE_W-1:0] spi_data_byte_rx;
   logic              spi_data_byte_rx_valid;
   logic              spi_dreq;
   logic [BYTE_W-1:0] spi_data_to_send;
   logic              spi_data_written;

   modport master (
      output spi_address_rx, spi_address_rx_valid,
      output spi_data_byte_rx, spi_data_byte_rx_valid,
      output spi_dreq,
      input  spi_data_to_send, spi_data_written
   );

   modport slave (
      input  spi_address_rx, spi_address_rx_valid,
      input  spi_data_byte_rx, spi_data_byte_rx_valid,
      input  spi_dreq,
      output spi_data_to_send, spi_data_written
   );

endinterface

// File: rtl/spi_reg_bank_rd_mux.sv
// Read-side byte select: RW registers, then RO status slots, 0x00 for unmapped addresses.
module spi_reg_rd_mux
   import spi_reg_bank_pkg::*;
#(
   parameter int BYTE_W = 8,
   parameter int NUM_RW = 16,
   parameter int NUM_RO = 4
) (
   input  logic [SPI_ADDR_W-1:0]    ptr,
   input  logic [NUM_RW*BYTE_W-1:0] reg_bytes,
   input  logic [NUM_RO*BYTE_W-1:0] status_in,
   output logic [BYTE_W-1:0]        rd_byte
);

   always_comb begin
      rd_byte = '0;
      for (int unsigned i = 0; i < NUM_RW; i++) begin
         if (ptr == SPI_ADDR_W'(i)) rd_byte = reg_bytes[i*BYTE_W +: BYTE_W];
      end
      for (int unsigned k = 0; k < NUM_RO; k++) begin
         if (ptr == SPI_ADDR_W'(NUM_RW + k)) rd_byte = status_in[k*BYTE_W +: BYTE_W];
      end
   end

endmodule

// File: rtl/spi_reg_bank.sv
// Address-mapped register bank behind the SPI core: auto-incrementing burst writes to RW
// registers and burst reads of RW + RO registers, answering each dreq with one TX byte.
module spi_reg_bank
   import spi_reg_bank_pkg::*;
#(
   parameter int                BYTE_W    = BYTE_W_DEF,
   parameter int                NUM_RW    = 16,
   parameter int                NUM_RO    = 4,
   parameter logic [BYTE_W-1:0] RESET_VAL = '0
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   spi_reg_bank_if.slave            spi,
   input  logic [NUM_RO*BYTE_W-1:0] status_in,
   output logic [NUM_RW*BYTE_W-1:0] reg_out,
   output logic [NUM_RW-1:0]        reg_wr_strobe
);

   localparam logic [SPI_ADDR_W:0] RW_LIM = (SPI_ADDR_W+1)'(NUM_RW);

   state_t                  state, state_nxt;
   logic [SPI_ADDR_W-1:0]   ptr, ptr_nxt;
   logic                    wr_en;
   logic [NUM_RW-1:0]       wr_hit;
   logic [BYTE_W-1:0]       rd_byte;
   logic [BYTE_W-1:0]       tx_nxt;
   logic [BYTE_W-1:0]       tx_q;
   logic                    written_q;

   spi_reg_rd_mux #(
      .BYTE_W (BYTE_W),
      .NUM_RW (NUM_RW),
      .NUM_RO (NUM_RO)
   ) u_rd_mux (
      .ptr       (ptr),
      .reg_bytes (reg_out),
      .status_in (status_in),
      .rd_byte   (rd_byte)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= ST_IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // An address strobe takes priority over everything; a dreq in the same cycle is answered with 0x00.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      wr_en     = 1'b0;
      tx_nxt    = '0;
      if (spi.spi_address_rx_valid) begin
         ptr_nxt   = spi.spi_address_rx[SPI_ADDR_W-1:0];
         state_nxt = spi.spi_address_rx[SPI_RW_BIT] ? ST_READ : ST_WRITE;
      end else begin
         case (state)
            ST_WRITE: begin
               if (spi.spi_data_byte_rx_valid) begin
                  wr_en   = ({1'b0, ptr} < RW_LIM);
                  ptr_nxt = ptr + SPI_ADDR_W'(1);
               end
            end
            ST_READ: begin
               if (spi.spi_dreq) begin
                  tx_nxt  = rd_byte;
                  ptr_nxt = ptr + SPI_ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      wr_hit = '0;
      for (int unsigned i = 0; i < NUM_RW; i++) begin
         wr_hit[i] = wr_en && (ptr == SPI_ADDR_W'(i));
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         reg_out       <= {NUM_RW{RESET_VAL}};
         reg_wr_strobe <= '0;
         tx_q          <= '0;
         written_q     <= 1'b0;
      end else begin
         reg_wr_strobe <= wr_hit;
         written_q     <= spi.spi_dreq;
         if (spi.spi_dreq) tx_q <= tx_nxt;
         for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (wr_hit[i]) reg_out[i*BYTE_W +: BYTE_W] <= spi.spi_data_byte_rx;
         end
      end
   end

   assign spi.spi_data_to_send = tx_q;
   assign spi.spi_data_written = written_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank; TX bytes are checked against a queue of expected responses.
module tb_spi_reg_bank;

   logic         sys_clk = 1'b0;
   logic         sys_rst_n = 1'b0;
   logic [31:0]  status_in = '0;
   logic [127:0] reg_out;
   logic [15:0]  reg_wr_strobe;

   logic [127:0] exp_regs = '0;
   logic [7:0]   exp_q[$];
   int           total = 0;
   int           bad = 0;

   always #5 sys_clk = ~sys_clk;

   spi_reg_bank_if #(.BYTE_W(8)) bus ();

   spi_reg_bank #(
      .BYTE_W    (8),
      .NUM_RW    (16),
      .NUM_RO    (4),
      .RESET_VAL (8'h00)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .spi           (bus.slave),
      .status_in     (status_in),
      .reg_out       (reg_out),
      .reg_wr_strobe (reg_wr_strobe)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle of stimulus; any dreq pushes its expected TX byte first.
   task automatic drive(input logic av, input logic [7:0] a, input logic dv,
                        input logic [7:0] d, input logic rq, input logic [7:0] exp_tx);
      @(negedge sys_clk);
      bus.spi_address_rx         = a;
      bus.spi_address_rx_valid   = av;
      bus.spi_data_byte_rx       = d;
      bus.spi_data_byte_rx_valid = dv;
      bus.spi_dreq               = rq;
      if (rq) exp_q.push_back(exp_tx);
      @(negedge sys_clk);
      bus.spi_address_rx_valid   = 1'b0;
      bus.spi_data_byte_rx_valid = 1'b0;
      bus.spi_dreq               = 1'b0;
   endtask

   task automatic addr(input logic [7:0] a);
      drive(1'b1, a, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic wdata(input logic [7:0] d);
      drive(1'b0, 8'h00, 1'b1, d, 1'b0, 8'h00);
   endtask

   task automatic rreq(input logic [7:0] exp_tx);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, exp_tx);
   endtask

   always @(negedge sys_clk) begin
      if (bus.spi_data_written === 1'b1) begin
         if (exp_q.size() == 0) chk("tx_unexpected_pulse", 128'd1, 128'd0);
         else                   chk("tx_byte", {120'd0, bus.spi_data_to_send}, {120'd0, exp_q.pop_front()});
      end
   end

   initial begin
      bus.spi_address_rx         = '0;
      bus.spi_address_rx_valid   = 1'b0;
      bus.spi_data_byte_rx       = '0;
      bus.spi_data_byte_rx_valid = 1'b0;
      bus.spi_dreq               = 1'b0;
      status_in                  = {8'h4D, 8'h6E, 8'h9B, 8'hC7};

      repeat (3) @(negedge sys_clk);
      chk("rst_reg_out", reg_out, 128'd0);
      chk("rst_strobe", {112'd0, reg_wr_strobe}, 128'd0);
      chk("rst_tx", {120'd0, bus.spi_data_to_send}, 128'd0);
      chk("rst_written", {127'd0, bus.spi_data_written}, 128'd0);
      sys_rst_n = 1'b1;

      // T1 write burst
      addr(8'h02);
      wdata(8'hA5); exp_regs[2*8 +: 8] = 8'hA5;
      chk("t1_strobe2", {112'd0, reg_wr_strobe}, 128'h0004);
      chk("t1_reg2", reg_out, exp_regs);
      wdata(8'h5A); exp_regs[3*8 +: 8] = 8'h5A;
      chk("t1_strobe3", {112'd0, reg_wr_strobe}, 128'h0008);
      wdata(8'h3C); exp_regs[4*8 +: 8] = 8'h3C;
      chk("t1_strobe4", {112'd0, reg_wr_strobe}, 128'h0010);
      chk("t1_regs", reg_out, exp_regs);
      @(negedge sys_clk);
      chk("t1_strobe_clear", {112'd0, reg_wr_strobe}, 128'd0);

      // T2 read burst
      addr(8'h00);
      wdata(8'h11); wdata(8'h22); wdata(8'h33);
      exp_regs[0 +: 24] = 24'h332211;
      chk("t2_preset", reg_out, exp_regs);
      addr(8'h80);
      rreq(8'h11); rreq(8'h22); rreq(8'h33);
      @(negedge sys_clk);
      chk("t2_written_clear", {127'd0, bus.spi_data_written}, 128'd0);
      chk("t2_tx_hold", {120'd0, bus.spi_data_to_send}, 128'h33);

      // T3 RO slots, unmapped reads, pointer wrap
      addr(8'h90);
      rreq(8'hC7); rreq(8'h9B);
      addr(8'h93);
      rreq(8'h4D); rreq(8'h00);
      addr(8'hFF);
      rreq(8'h00); rreq(8'h11);

      // T4 write running past the last RW register
      addr(8'h0F);
      wdata(8'h77); exp_regs[15*8 +: 8] = 8'h77;
      chk("t4_strobe15", {112'd0, reg_wr_strobe}, 128'h8000);
      wdata(8'h88);
      chk("t4_oor_strobe", {112'd0, reg_wr_strobe}, 128'd0);
      chk("t4_regs", reg_out, exp_regs);

      // T5 collisions
      drive(1'b1, 8'h05, 1'b1, 8'hEE, 1'b0, 8'h00);
      chk("t5_addr_data_strobe", {112'd0, reg_wr_strobe}, 128'd0);
      chk("t5_addr_data_regs", reg_out, exp_regs);
      rreq(8'h00);
      wdata(8'h44); exp_regs[5*8 +: 8] = 8'h44;
      chk("t5_retarget_write", reg_out, exp_regs);
      chk("t5_strobe5", {112'd0, reg_wr_strobe}, 128'h0020);
      drive(1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 8'h00);
      rreq(8'h22);
      drive(1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 8'h33);
      rreq(8'h5A);
      chk("t5_read_no_write", reg_out, exp_regs);

      // T6 asynchronous reset in the middle of a write burst
      addr(8'h08);
      wdata(8'hD1); exp_regs[8*8 +: 8] = 8'hD1;
      chk("t6_first_byte", reg_out, exp_regs);
      chk("t6_tx_before_rst", {120'd0, bus.spi_data_to_send}, 128'h5A);
      #2 sys_rst_n = 1'b0;
      #1;
      exp_regs = '0;
      chk("t6_rst_regs", reg_out, exp_regs);
      chk("t6_rst_strobe", {112'd0, reg_wr_strobe}, 128'd0);
      chk("t6_rst_tx", {120'd0, bus.spi_data_to_send}, 128'd0);
      chk("t6_rst_written", {127'd0, bus.spi_data_written}, 128'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      wdata(8'hD2);
      chk("t6_idle_data_strobe", {112'd0, reg_wr_strobe}, 128'd0);
      wdata(8'hD3);
      chk("t6_idle_data_regs", reg_out, exp_regs);
      rreq(8'h00);

      repeat (3) @(negedge sys_clk);
      chk("tx_pending", 128'(exp_q.size()), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
